cswap: RTL and testbench
========================

Name: cswap

Overview:
- Registered, bit-parallel Fredkin (controlled-swap) gate. Control vector A passes through unchanged.
- For every bit where A is 1, the corresponding bits of B and C are exchanged. Where A is 0, B and C pass straight through.
- Reversible-logic primitive for datapaths built from conservative gates. One-cycle latency, valid-qualified.

Parameters:
- WIDTH, 1, bit width of A, B, C and of each output; must be at least 1.
- CNT_W, 16, width of the optional swap-statistics counter; must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  A/B/C are sampled on this clock edge when high
- A  input  WIDTH  control vector
- B  input  WIDTH  data operand 1
- C  input  WIDTH  data operand 2
- out_valid  output  1  A1/B1/C1 hold a freshly computed result this cycle
- A1  output  WIDTH  registered copy of A
- B1  output  WIDTH  registered (~A & B) | (A & C)
- C1  output  WIDTH  registered (~A & C) | (A & B)
- swap_cnt  output  CNT_W  present only with CSWAP_STATS_EN (see Optional Feature)

Behaviour:
- Design: one clock, clk. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk, and the block has no asynchronous reset path.
- Reset (rst_n=0 at a rising edge): A1, B1, C1 and out_valid go to 0 at that edge. Reset overrides in_valid.
- Reset may be asserted mid-stream. A result in flight is discarded, and out_valid is 0 in the cycle after the reset edge.
- Normal edge with in_valid=1:
  - A1 <= A.
  - B1 <= per-bit mux(A ? C : B).
  - C1 <= per-bit mux(A ? B : C).
  - out_valid <= 1.
- Normal edge with in_valid=0: A1/B1/C1 hold their previous values and out_valid <= 0.
- Latency: exactly one clock, input edge to output. Throughput is one result per cycle. There is no backpressure.
- Bits are independent. No arithmetic is performed and there are no carries or width growth.
- Invariants:
  - Per bit position, A1+B1+C1 equals A+B+C (conservative gate).
  - Feeding A1/B1/C1 back in with in_valid=1 reproduces the original A/B/C (self-inverse).
- Output A1 never differs from the A sampled on the same edge.
- Inputs containing X/Z are not checked. Outputs follow mux semantics.

Optional Feature:
- Macro CSWAP_STATS_EN.
- When defined:
  - Adds output swap_cnt[CNT_W-1:0], which resets to 0 on rst_n=0.
  - On each edge with in_valid=1, swap_cnt adds popcount(A & (B ^ C)), i.e. the number of bit positions whose values actually changed.
  - The counter saturates at 2^CNT_W-1 and never wraps.
  - It updates on the same edge as A1/B1/C1.
- When not defined: the port and all counter/popcount logic are absent. The data path behaves identically in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1 and A=B=C=1 -> A1=B1=C1=0 and out_valid=0. Release rst_n -> first result appears one edge later.
- Exhaustive truth table, WIDTH=1: drive all 8 A/B/C combinations with in_valid=1.
  - A=0 cases: (B1,C1)=(B,C), e.g. 0,1,0 -> 0,1,0.
  - A=1 cases: (B1,C1)=(C,B), e.g. 1,1,0 -> 1,0,1 and 1,0,1 -> 1,1,0.
  - Each output is checked one cycle later.
- Bit-parallel, WIDTH=8: A=8'hF0, B=8'hAA, C=8'h55 -> A1=8'hF0, B1=8'h5A, C1=8'hA5, out_valid=1 one cycle later.
- Hold and reversibility:
  - Deassert in_valid -> outputs hold and out_valid=0.
  - Feed 8'hF0/8'h5A/8'hA5 back in -> outputs return to F0/AA/55.
  - Per-bit ones count is preserved.
- Mid-stream reset: stream 4 back-to-back vectors, assert rst_n=0 on the 3rd edge -> outputs 0 and out_valid 0 on the next cycle. No stale result appears after release.
- CSWAP_STATS_EN: apply A=8'hF0, B=8'hAA, C=8'h55 twice -> swap_cnt goes 0, 4, 8.
  - With CNT_W=3, repeat the vector -> swap_cnt saturates at 7 and does not wrap.

Source files
------------

// File: rtl/cswap.sv
// cswap: registered, bit-parallel Fredkin (controlled-swap) gate.
//
// For every bit position where control A is 1, the matching bits of B and C
// are exchanged; where A is 0 they pass straight through. A is forwarded
// unchanged. The gate is conservative (per-bit ones count preserved) and
// self-inverse. Results appear exactly one clock after the sampling edge.
//
// Parameters:
//   WIDTH  width of A, B, C and of each data output (>= 1)
//   CNT_W  width of the optional swap-statistics counter (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   A/B/C are sampled on this edge when high
//   A, B, C    control vector and the two data operands
//   out_valid  A1/B1/C1 hold a freshly computed result this cycle
//   A1         registered copy of A
//   B1         registered (~A & B) | (A & C)
//   C1         registered (~A & C) | (A & B)
//   swap_cnt   saturating count of bit positions whose values actually
//              changed, i.e. the running sum of popcount(A & (B ^ C))
//
// Build option:
//   CSWAP_STATS_EN  when defined, adds swap_cnt and its popcount logic.
//                   The data path is identical in both builds.

module cswap #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  output logic             out_valid,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] B1,
  output logic [WIDTH-1:0] C1
`ifdef CSWAP_STATS_EN
  ,
  output logic [CNT_W-1:0] swap_cnt
`endif
);

  if (WIDTH < 1) begin : g_bad_width
    $error("cswap: WIDTH must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cswap: CNT_W must be at least 1");
  end

  logic [WIDTH-1:0] b_mux;
  logic [WIDTH-1:0] c_mux;

  always_comb begin
    b_mux = (~A & B) | (A & C);
    c_mux = (~A & C) | (A & B);
  end

  // Data registers hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      A1        <= '0;
      B1        <= '0;
      C1        <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        A1 <= A;
        B1 <= b_mux;
        C1 <= c_mux;
      end
    end
  end

`ifdef CSWAP_STATS_EN
  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  // One spare bit above the wider operand so the sum never overflows and
  // saturation can be detected from the bits above CNT_W.
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [WIDTH-1:0] swap_bits;
  logic [POP_W-1:0] pop_cnt;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    swap_bits = A & (B ^ C);
    pop_cnt   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_cnt = pop_cnt + POP_W'(swap_bits[i]);
    end
    cnt_sum = SUM_W'(swap_cnt) + SUM_W'(pop_cnt);
    cnt_nxt = (cnt_sum[SUM_W-1:CNT_W] != '0) ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      swap_cnt <= '0;
    end else if (in_valid) begin
      swap_cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_cswap.sv
module tb_cswap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;

  // WIDTH=1 instance
  logic [0:0] a_w1, b_w1, c_w1;
  logic       ov_w1;
  logic [0:0] a1_w1, b1_w1, c1_w1;

  // WIDTH=8 instances (shared inputs)
  logic [7:0] a, b, c;
  logic       ov8;
  logic [7:0] a1_8, b1_8, c1_8;

`ifdef CSWAP_STATS_EN
  logic [15:0] cnt_w1;
  logic [15:0] cnt8;
  logic        ov_s;
  logic [7:0]  a1_s, b1_s, c1_s;
  logic [2:0]  cnt_sat;
`endif

  cswap #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a_w1), .B(b_w1), .C(c_w1),
    .out_valid(ov_w1), .A1(a1_w1), .B1(b1_w1), .C1(c1_w1)
`ifdef CSWAP_STATS_EN
    , .swap_cnt(cnt_w1)
`endif
  );

  cswap #(.WIDTH(8), .CNT_W(16)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a), .B(b), .C(c),
    .out_valid(ov8), .A1(a1_8), .B1(b1_8), .C1(c1_8)
`ifdef CSWAP_STATS_EN
    , .swap_cnt(cnt8)
`endif
  );

`ifdef CSWAP_STATS_EN
  cswap #(.WIDTH(8), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A(a), .B(b), .C(c),
    .out_valid(ov_s), .A1(a1_s), .B1(b1_s), .C1(c1_s),
    .swap_cnt(cnt_sat)
  );
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic       m_v8, m_v1;
  logic [7:0] m_a8, m_b8, m_c8;
  logic       m_a1, m_b1, m_c1;
  int         m_cnt8, m_cnt_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Swap rule stated directly: where the control bit is set, the two
  // operands trade places.
  function automatic void ref_swap(input logic [7:0] ca, input logic [7:0] cb,
                                   input logic [7:0] cc,
                                   output logic [7:0] rb, output logic [7:0] rc);
    for (int i = 0; i < 8; i++) begin
      if (ca[i]) begin
        rb[i] = cc[i];
        rc[i] = cb[i];
      end else begin
        rb[i] = cb[i];
        rc[i] = cc[i];
      end
    end
  endfunction

  function automatic int cons_err(input logic [7:0] xa, input logic [7:0] xb,
                                  input logic [7:0] xc, input logic [7:0] ya,
                                  input logic [7:0] yb, input logic [7:0] yc);
    int e = 0;
    for (int i = 0; i < 8; i++)
      if (int'(xa[i]) + int'(xb[i]) + int'(xc[i]) != int'(ya[i]) + int'(yb[i]) + int'(yc[i]))
        e++;
    return e;
  endfunction

  task automatic step();
    logic [7:0] nb, nc, nb1, nc1;
    int pop;
    ref_swap(a, b, c, nb, nc);
    ref_swap({7'd0, a_w1}, {7'd0, b_w1}, {7'd0, c_w1}, nb1, nc1);
    pop = $countones(a & (b ^ c));
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_v8 = 0; m_a8 = 0; m_b8 = 0; m_c8 = 0;
      m_v1 = 0; m_a1 = 0; m_b1 = 0; m_c1 = 0;
      m_cnt8 = 0; m_cnt_sat = 0;
    end else begin
      m_v8 = in_valid;
      m_v1 = in_valid;
      if (in_valid) begin
        m_a8 = a; m_b8 = nb; m_c8 = nc;
        m_a1 = a_w1; m_b1 = nb1[0]; m_c1 = nc1[0];
        m_cnt8    = (m_cnt8 + pop > 65535) ? 65535 : m_cnt8 + pop;
        m_cnt_sat = (m_cnt_sat + pop > 7) ? 7 : m_cnt_sat + pop;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ov8"}, 32'(ov8),  32'(m_v8));
    chk({tag, "_a1_8"}, 32'(a1_8), 32'(m_a8));
    chk({tag, "_b1_8"}, 32'(b1_8), 32'(m_b8));
    chk({tag, "_c1_8"}, 32'(c1_8), 32'(m_c8));
    chk({tag, "_ov1"}, 32'(ov_w1), 32'(m_v1));
    chk({tag, "_a1_1"}, 32'(a1_w1), 32'(m_a1));
    chk({tag, "_b1_1"}, 32'(b1_w1), 32'(m_b1));
    chk({tag, "_c1_1"}, 32'(c1_w1), 32'(m_c1));
`ifdef CSWAP_STATS_EN
    chk({tag, "_cnt8"}, 32'(cnt8), 32'(m_cnt8));
    chk({tag, "_cnt_sat"}, 32'(cnt_sat), 32'(m_cnt_sat));
    chk({tag, "_b1_sat"}, 32'(b1_s), 32'(m_b8));
`endif
  endtask

  typedef struct {
    logic a, b, c;
    logic ea, eb, ec;
  } tt1_t;

  typedef struct {
    logic [7:0] a, b, c;
    logic       v;
    logic [7:0] ea, eb, ec;
    logic       ev;
  } tt8_t;

  tt1_t tt1[8];
  tt8_t tt8[6];

  initial begin
    tt1[0] = '{0, 0, 0, 0, 0, 0};
    tt1[1] = '{0, 0, 1, 0, 0, 1};
    tt1[2] = '{0, 1, 0, 0, 1, 0};
    tt1[3] = '{0, 1, 1, 0, 1, 1};
    tt1[4] = '{1, 0, 0, 1, 0, 0};
    tt1[5] = '{1, 0, 1, 1, 1, 0};
    tt1[6] = '{1, 1, 0, 1, 0, 1};
    tt1[7] = '{1, 1, 1, 1, 1, 1};

    tt8[0] = '{8'hF0, 8'hAA, 8'h55, 1'b1, 8'hF0, 8'h5A, 8'hA5, 1'b1};
    tt8[1] = '{8'h12, 8'h34, 8'h56, 1'b0, 8'hF0, 8'h5A, 8'hA5, 1'b0};
    tt8[2] = '{8'hF0, 8'h5A, 8'hA5, 1'b1, 8'hF0, 8'hAA, 8'h55, 1'b1};
    tt8[3] = '{8'h0F, 8'hFF, 8'h00, 1'b1, 8'h0F, 8'hF0, 8'h0F, 1'b1};
    tt8[4] = '{8'hFF, 8'h12, 8'h34, 1'b1, 8'hFF, 8'h34, 8'h12, 1'b1};
    tt8[5] = '{8'h00, 8'h12, 8'h34, 1'b1, 8'h00, 8'h12, 8'h34, 1'b1};

    // Reset with in_valid high and all-ones inputs
    rst_n = 0; in_valid = 1;
    a = 8'hFF; b = 8'hFF; c = 8'hFF;
    a_w1 = 1; b_w1 = 1; c_w1 = 1;
    m_v8 = 0; m_a8 = 0; m_b8 = 0; m_c8 = 0;
    m_v1 = 0; m_a1 = 0; m_b1 = 0; m_c1 = 0;
    m_cnt8 = 0; m_cnt_sat = 0;
    step();
    step();
    chk("rst_ov8", 32'(ov8), 0);
    chk("rst_a1_8", 32'(a1_8), 0);
    chk("rst_b1_8", 32'(b1_8), 0);
    chk("rst_c1_8", 32'(c1_8), 0);
    chk("rst_ov1", 32'(ov_w1), 0);
    chk("rst_abc_1", 32'({a1_w1, b1_w1, c1_w1}), 0);
`ifdef CSWAP_STATS_EN
    chk("rst_cnt8", 32'(cnt8), 0);
    chk("rst_cnt_sat", 32'(cnt_sat), 0);
`endif

    // First result one edge after release
    rst_n = 1;
    a = 8'hF0; b = 8'hAA; c = 8'h55;
    step();
    chk("rel_ov8", 32'(ov8), 1);
    chk("rel_b1_8", 32'(b1_8), 32'h5A);
    check_model("rel");

    // Exhaustive WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      a_w1 = tt1[i].a; b_w1 = tt1[i].b; c_w1 = tt1[i].c;
      step();
      chk($sformatf("tt1_%0d_a1", i), 32'(a1_w1), 32'(tt1[i].ea));
      chk($sformatf("tt1_%0d_b1", i), 32'(b1_w1), 32'(tt1[i].eb));
      chk($sformatf("tt1_%0d_c1", i), 32'(c1_w1), 32'(tt1[i].ec));
      chk($sformatf("tt1_%0d_ov", i), 32'(ov_w1), 1);
    end

    // WIDTH=8 vectors: bit-parallel, hold, self-inverse
    for (int i = 0; i < 6; i++) begin
      logic [7:0] pa, pb, pc;
      a = tt8[i].a; b = tt8[i].b; c = tt8[i].c; in_valid = tt8[i].v;
      pa = a; pb = b; pc = c;
      step();
      chk($sformatf("tt8_%0d_a1", i), 32'(a1_8), 32'(tt8[i].ea));
      chk($sformatf("tt8_%0d_b1", i), 32'(b1_8), 32'(tt8[i].eb));
      chk($sformatf("tt8_%0d_c1", i), 32'(c1_8), 32'(tt8[i].ec));
      chk($sformatf("tt8_%0d_ov", i), 32'(ov8), 32'(tt8[i].ev));
      if (tt8[i].v)
        chk($sformatf("tt8_%0d_cons", i), 32'(cons_err(pa, pb, pc, a1_8, b1_8, c1_8)), 0);
      check_model($sformatf("tt8_%0d", i));
    end

    // Mid-stream reset: 4 back-to-back vectors, reset on the 3rd edge
    in_valid = 1;
    a = 8'h3C; b = 8'h11; c = 8'hEE; step(); check_model("ms0");
    a = 8'hC3; b = 8'h22; c = 8'hDD; step(); check_model("ms1");
    rst_n = 0;
    a = 8'hFF; b = 8'h0F; c = 8'hF0; step();
    chk("ms_rst_ov", 32'(ov8), 0);
    chk("ms_rst_data", 32'({a1_8, b1_8, c1_8}), 0);
    rst_n = 1; in_valid = 0;
    step();
    chk("ms_rel_ov", 32'(ov8), 0);
    chk("ms_rel_data", 32'({a1_8, b1_8, c1_8}), 0);
    in_valid = 1;
    a = 8'h5A; b = 8'h96; c = 8'h69; step(); check_model("ms3");

`ifdef CSWAP_STATS_EN
    // Counter sequence 0, 4, 8 and saturation at 7 for CNT_W=3
    rst_n = 0; step();
    chk("st_cnt8_0", 32'(cnt8), 0);
    chk("st_sat_0", 32'(cnt_sat), 0);
    rst_n = 1; in_valid = 1;
    a = 8'hF0; b = 8'hAA; c = 8'h55;
    step();
    chk("st_cnt8_1", 32'(cnt8), 4);
    chk("st_sat_1", 32'(cnt_sat), 4);
    step();
    chk("st_cnt8_2", 32'(cnt8), 8);
    chk("st_sat_2", 32'(cnt_sat), 7);
    step();
    chk("st_cnt8_3", 32'(cnt8), 12);
    chk("st_sat_3", 32'(cnt_sat), 7);
    in_valid = 0; a = 8'hFF; b = 8'h00; c = 8'hFF;
    step();
    chk("st_hold", 32'(cnt8), 12);
`endif

    // Randomized traffic against the model, occasional resets
    for (int n = 0; n < 300; n++) begin
      rst_n    = ($urandom_range(0, 19) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      a_w1 = 1'($urandom); b_w1 = 1'($urandom); c_w1 = 1'($urandom);
      step();
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
